// File: rtl/game_clock_pkg.sv
// Shared defaults and counter-width helper for the game tick clock and its divider.
package game_clock_pkg;

  localparam int DEFAULT_HALF_PERIOD     = 25_000_000;
  localparam int DEFAULT_SIM_HALF_PERIOD = 4;

  // Width needed to hold 0..length-1, never less than one bit.
  function automatic int cnt_width(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..LENGTH-1 counter with a one-cycle terminal-count pulse.
// Reusable by any game timer; only the count length is configurable.
module tick_divider
  import game_clock_pkg::*;
#(
  parameter int LENGTH = DEFAULT_SIM_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tc
);

  localparam int           W    = cnt_width(LENGTH);
  localparam logic [W-1:0] LAST = W'(LENGTH - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q >= LAST);
  // tc is qualified by enable so a frozen counter never signals wrap.
  assign tc      = enable && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_clock.sv
// 50%-duty game tick clock: toggles every half-period of clk cycles, freezable by pause.
// Define GAME_CLOCK_SIM_EN to run from SIM_HALF_PERIOD instead of HALF_PERIOD.
module game_clock
  import game_clock_pkg::*;
#(
  parameter int HALF_PERIOD     = DEFAULT_HALF_PERIOD,
  parameter int SIM_HALF_PERIOD = DEFAULT_SIM_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic game_clk
);

`ifdef GAME_CLOCK_SIM_EN
  localparam bit SIM_EN = 1'b1;
`else
  localparam bit SIM_EN = 1'b0;
`endif

  localparam int EFF_HALF_PERIOD = SIM_EN ? SIM_HALF_PERIOD : HALF_PERIOD;

  logic wrap;
  logic game_clk_q, game_clk_d;

  tick_divider #(
    .LENGTH (EFF_HALF_PERIOD)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (!pause),
    .tc     (wrap)
  );

  assign game_clk_d = game_clk_q ^ wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_clk_q <= 1'b0;
    end else begin
      game_clk_q <= game_clk_d;
    end
  end

  assign game_clk = game_clk_q;

endmodule

// File: tb/tb_game_clock.sv
// Self-checking bench for game_clock: three instances (half-periods 4, 3, 1), vector table,
// hand-written corner sequences and a randomized run against an edge-count reference model.
`timescale 1ns/1ps
module tb_game_clock;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic g4, g3, g1;

  int checks = 0;
  int errors = 0;

  // Both parameters equal so behaviour is the same with or without GAME_CLOCK_SIM_EN.
  game_clock #(.HALF_PERIOD(4), .SIM_HALF_PERIOD(4)) u4 (.clk(clk), .rst(rst), .pause(pause), .game_clk(g4));
  game_clock #(.HALF_PERIOD(3), .SIM_HALF_PERIOD(3)) u3 (.clk(clk), .rst(rst), .pause(pause), .game_clk(g3));
  game_clock #(.HALF_PERIOD(1), .SIM_HALF_PERIOD(1)) u1 (.clk(clk), .rst(rst), .pause(pause), .game_clk(g1));

  always #5 clk = ~clk;

  // Reference: count of edges that actually counted since reset; level = (n / H) mod 2.
  int active_edges = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) active_edges <= 0;
    else if (!pause) active_edges <= active_edges + 1;
  end

  function automatic logic model_level(input int h);
    return logic'((active_edges / h) % 2);
  endfunction

  function automatic logic cur(input int sel);
    case (sel)
      4:       return g4;
      3:       return g3;
      default: return g1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Counts rising clk edges until instance sel shows level lvl; -1 on timeout.
  task automatic wait_level(input int sel, input logic lvl, output int edges);
    edges = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (cur(sel) === lvl) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic p);
    @(negedge clk);
    rst = 1'b1;
    pause = p;
    #100;
    check("level_in_reset", int'(g4), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst;
    logic pause;
    logic e4;
    logic e3;
    logic e1;
  } vec_t;

  vec_t vecs[14];
  int   e;
  logic held;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    #1;
    check("reset_level_g4", int'(g4), 0);
    check("reset_level_g1", int'(g1), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      pause = vecs[i].pause;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_g4", i), int'(g4), int'(vecs[i].e4));
      check($sformatf("vec%0d_g3", i), int'(g3), int'(vecs[i].e3));
      check($sformatf("vec%0d_g1", i), int'(g1), int'(vecs[i].e1));
    end

    // First rise on 4th edge after release, then 4 edges low/high (40 ns each).
    do_reset(1'b0);
    wait_level(4, 1'b1, e); check("first_rise_edge", e, 4);
    wait_level(4, 1'b0, e); check("high_time_edges", e, 4);
    wait_level(4, 1'b1, e); check("low_time_edges", e, 4);

    // Pause for 3 cycles with the counter at 2: rise moves from edge 4 to edge 7.
    do_reset(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("frozen_during_pause", int'(g4), 0);
    @(negedge clk);
    pause = 1'b0;
    wait_level(4, 1'b1, e);
    check("paused_rise_edge", e + 5, 7);

    // rst and pause together, then pause alone: no toggles until pause drops.
    do_reset(1'b1);
    held = 1'b0;
    repeat (10) begin
      @(negedge clk);
      held = held | g4 | g3 | g1;
    end
    check("no_toggle_while_paused", int'(held), 0);
    pause = 1'b0;
    wait_level(4, 1'b1, e); check("rise_after_unpause", e, 4);

    // Short reset pulse between edges while high clears before the next edge.
    do_reset(1'b0);
    wait_level(4, 1'b1, e); check("high_before_pulse", e, 4);
    #1 rst = 1'b1;
    #2 check("async_clear_in_pulse", int'(g4), 0);
    #3 rst = 1'b0;
    #1 check("still_low_after_pulse", int'(g4), 0);
    wait_level(4, 1'b1, e); check("rise_after_pulse", e, 4);

    // Half-period 1 toggles every edge; pause holds the level.
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hp1_edge%0d", k), int'(g1), k % 2);
    end
    @(negedge clk);
    held = g1;
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hp1_frozen", int'(g1), int'(held));
    @(negedge clk);
    pause = 1'b0;

    // Half-period 3 gives a 6-cycle period.
    do_reset(1'b0);
    wait_level(3, 1'b1, e); check("hp3_first_rise", e, 3);
    wait_level(3, 1'b0, e); check("hp3_high", e, 3);
    wait_level(3, 1'b1, e); check("hp3_low", e, 3);

    // Randomized run against the edge-count model.
    @(negedge clk);
    rst = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check("rand_g4", int'(g4), int'(model_level(4)));
      check("rand_g3", int'(g3), int'(model_level(3)));
      check("rand_g1", int'(g1), int'(model_level(1)));
      rst = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_clock.md
GAME_CLOCK -- requirements
Module: game_clock

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 25_000_000, meaning clk cycles per game_clk half-period (2 Hz at 100 MHz clk); legal range >= 1.
REQ-002 SHALL have parameter SIM_HALF_PERIOD, default 4, meaning the half-period used when the simulation macro is defined; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port pause, input, 1 bit: synchronous freeze request, active-high.
REQ-006 SHALL have port game_clk, output, 1 bit: registered 50%-duty game tick clock (period 2*HALF_PERIOD clk cycles).

Function
REQ-007 SHALL hold an internal divide counter of width clog2(effective half-period), minimum 1 bit.
REQ-008 SHALL, on each clk edge with rst low and pause low, increment the counter if it is below half-period-1; otherwise clear it to 0 and invert game_clk on that same edge.
REQ-009 SHALL, on each clk edge with pause high, hold both counter and game_clk unchanged (no glitch, no toggle).
REQ-010 SHALL, on pause deassertion, resume counting from the held value; total time to next toggle equals the remaining count plus the number of paused cycles.
REQ-011 SHALL toggle game_clk every clk cycle when the effective half-period is 1 (counter stays 0).
REQ-012 SHALL produce first 0->1 transition on the half-period-th rising edge after rst deasserts (pause low throughout).
REQ-013 SHALL drive game_clk directly from a flop; no combinational path from pause or rst other than the asynchronous clear.
REQ-014 SHALL treat rst and pause high together as reset (rst has priority).

Reset
REQ-015 SHALL, while rst high, asynchronously force counter = 0 and game_clk = 0, independent of clk.
REQ-016 SHALL, on rst assertion mid-period (game_clk high or counter nonzero), clear immediately; counting restarts from 0 after release.
REQ-017 SHALL deassert reset cleanly: first counting edge is the first rising clk edge with rst low.

Configuration
REQ-018 SHALL, when macro GAME_CLOCK_SIM_EN is defined, use SIM_HALF_PERIOD as the effective half-period and size the counter from it.
REQ-019 SHALL, when GAME_CLOCK_SIM_EN is undefined, use HALF_PERIOD; SIM_HALF_PERIOD then has no effect.

Structure
REQ-020 SHALL place default HALF_PERIOD, default SIM_HALF_PERIOD and the counter-width helper constant in shared package game_clock_pkg.
REQ-021 SHALL implement the counter as one sub-module tick_divider (inputs clk, rst, enable; output one-cycle terminal-count pulse); game_clock holds the game_clk toggle flop and maps pause to enable = !pause.
REQ-022 SHALL keep tick_divider parameterized only by its count length, reusable by other game timers.

Verification (GAME_CLOCK_SIM_EN defined, SIM_HALF_PERIOD = 4, clk period 10 ns)
REQ-023 SHALL verify: rst high 100 ns then low, pause low -> game_clk 0 during reset, rises at 4th edge after release, period 80 ns, duty 40/40 ns.
REQ-024 SHALL verify: pause high 3 cycles when counter = 2 -> game_clk and counter frozen; toggle occurs 3 cycles later than unpaused (edge 7 instead of 4).
REQ-025 SHALL verify: rst and pause both high 100 ns, then rst low with pause high 100 ns -> game_clk stays 0, no toggle; after pause low, first rise 4 edges later.
REQ-026 SHALL verify: rst pulsed 5 ns between clk edges while game_clk high -> game_clk 0 within that interval, before the next clk edge.
REQ-027 SHALL verify: SIM_HALF_PERIOD = 1 -> game_clk toggles on every rising clk edge (period 20 ns); pause high freezes it at current level.
REQ-028 SHALL verify: macro undefined, HALF_PERIOD = 3 -> game_clk period 6 clk cycles; SIM_HALF_PERIOD ignored.
